tt6502_bus_mux: RTL

Bus-phase multiplexer between the 6502 core and the Tiny Tapeout top-level pins. It takes one core memory request at a time: 16-bit address, 8-bit write data and a read/write flag. It serialises the request over the single 8-bit bidirectional pin bus as address-low, address-high and data phases, honours an external ready/wait line with a timeout, and returns read data to the core with a one-cycle acknowledge.

---
 rtl/tt6502_pkg.sv | 21 ++
 rtl/tt6502_phase_timer.sv | 35 +++
 rtl/tt6502_bus_mux.sv | 123 ++++++++++++
 3 files changed

// File: rtl/tt6502_pkg.sv
// Shared definitions for the tt6502 pin-bus multiplexer.
// Phase codes double as the FSM state encoding.
package tt6502_pkg;

    typedef logic [1:0] bus_phase_t;

    localparam bus_phase_t PH_IDLE = 2'b00;
    localparam bus_phase_t PH_ALO  = 2'b01;
    localparam bus_phase_t PH_AHI  = 2'b10;
    localparam bus_phase_t PH_DATA = 2'b11;

    localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = PH_IDLE,
        ST_ALO  = PH_ALO,
        ST_AHI  = PH_AHI,
        ST_DATA = PH_DATA
    } state_t;

endpackage

// File: rtl/tt6502_phase_timer.sv
// 8-bit phase counter, cleared on every state change, with the
// minimum-phase and timeout compare flags.
module tt6502_phase_timer
    import tt6502_pkg::*;
#(
    parameter int unsigned PHASE_CYC   = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic phase_done,
    output logic timeout
);

    localparam logic [7:0] PH_LAST = 8'(PHASE_CYC - 1);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] count;

    // Saturate so a long IDLE never wraps into a false compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'h00;
        end else if (clr) begin
            count <= 8'h00;
        end else if (count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    assign phase_done = (count >= PH_LAST);
    assign timeout    = (count >= TO_LAST);

endmodule

// File: rtl/tt6502_bus_mux.sv
// Serialises one 6502 core access over the 8-bit Tiny Tapeout pin bus
// as address-low, address-high and data phases with ready/timeout.
module tt6502_bus_mux
    import tt6502_pkg::*;
#(
    parameter int unsigned PHASE_CYC   = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        err,
    output logic [7:0]  bus_out,
    output logic        bus_oe,
    input  logic [7:0]  bus_in,
    output logic [1:0]  phase,
    output logic        we_pin,
    input  logic        ext_rdy
);

    state_t      state, state_n;
    logic [15:0] addr_q, addr_n;
    logic [7:0]  wdata_q, wdata_n;
    logic        we_q, we_n;
    logic        phase_done, timeout;
    logic        accept, done_ok, done_to;
    logic [7:0]  bus_out_n;
    logic        bus_oe_n, we_pin_n;

    tt6502_phase_timer #(
        .PHASE_CYC   (PHASE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clr        (state_n != state),
        .phase_done (phase_done),
        .timeout    (timeout)
    );

    // A ready response wins over a coincident timeout.
    assign accept  = (state == ST_IDLE) && req && !ack;
    assign done_ok = (state == ST_DATA) && phase_done && ext_rdy;
    assign done_to = (state == ST_DATA) && timeout && !done_ok;

    assign addr_n  = accept ? addr  : addr_q;
    assign wdata_n = accept ? wdata : wdata_q;
    assign we_n    = accept ? we    : we_q;

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: if (accept)             state_n = ST_ALO;
            ST_ALO:  if (phase_done)         state_n = ST_AHI;
            ST_AHI:  if (phase_done)         state_n = ST_DATA;
            ST_DATA: if (done_ok || done_to) state_n = ST_IDLE;
            default:                         state_n = ST_IDLE;
        endcase
    end

    // Pin outputs are computed for the next state and registered.
    always_comb begin
        bus_out_n = 8'h00;
        bus_oe_n  = 1'b0;
        we_pin_n  = 1'b0;
        unique case (state_n)
            ST_ALO: begin
                bus_out_n = addr_n[7:0];
                bus_oe_n  = 1'b1;
                we_pin_n  = we_n;
            end
            ST_AHI: begin
                bus_out_n = addr_n[15:8];
                bus_oe_n  = 1'b1;
                we_pin_n  = we_n;
            end
            ST_DATA: begin
                bus_out_n = we_n ? wdata_n : 8'h00;
                bus_oe_n  = we_n;
                we_pin_n  = we_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            we_q    <= 1'b0;
            bus_out <= 8'h00;
            bus_oe  <= 1'b0;
            we_pin  <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= 8'h00;
        end else begin
            state   <= state_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            we_q    <= we_n;
            bus_out <= bus_out_n;
            bus_oe  <= bus_oe_n;
            we_pin  <= we_pin_n;
            ack     <= done_ok || done_to;
            err     <= done_to;
            if (done_ok && !we_q) begin
                rdata <= bus_in;
            end else if (done_to && !we_q) begin
                rdata <= TIMEOUT_RDATA;
            end
        end
    end

    assign phase = state;

endmodule
